// File: rtl/stat_sched.sv
// Round-robin scheduler sharing one running max/min/average datapath between NREQ requesters.
// Optional stall watchdog built in when STAT_SCHED_TIMEOUT_EN is defined.
module stat_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int LENW    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   CLOCK,
   input  logic                   RESET_N,
   input  logic [NREQ-1:0]        REQ,
   input  logic [NREQ*LENW-1:0]   LEN,
   input  logic [NREQ*WIDTH-1:0]  DIN,
   input  logic [NREQ-1:0]        DIN_VALID,
   output logic                   DIN_READY,
   output logic [NREQ-1:0]        GNT,
   output logic [NREQ-1:0]        DONE,
   output logic [WIDTH-1:0]       RESULT,
   output logic                   ABORT,
   output logic                   DP_CLEAR,
   output logic                   DP_ENABLE,
   output logic                   DP_RESTART,
   output logic [WIDTH-1:0]       DP_DATA,
   input  logic [WIDTH-1:0]       DP_OUT,
   output logic                   BUSY
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, RESTART, CAPTURE} state_t;

   state_t            state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     win;
   logic [IW-1:0]     win_next;
   logic [IW-1:0]     pick;
   logic              pick_valid;
   logic [LENW-1:0]   count;
   logic              req_w;
   logic              valid_w;
   logic [WIDTH-1:0]  din_w;
   logic              stall_expire;
   logic              abandon;

   always_comb begin
      req_w    = REQ[win];
      valid_w  = DIN_VALID[win];
      din_w    = DIN[int'(win)*WIDTH +: WIDTH];
      win_next = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
      abandon  = ((state == CLEAR) || (state == STREAM)) && (!req_w || stall_expire);
   end

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_valid && REQ[(int'(ptr) + i) % NREQ]) begin
            pick_valid = 1'b1;
            pick       = IW'((int'(ptr) + i) % NREQ);
         end
      end
   end

`ifdef STAT_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0] stall;

   assign stall_expire = (state == STREAM) && !valid_w && (stall == SW'(TIMEOUT-1));

   always_ff @(posedge CLOCK) begin
      if (!RESET_N || state != STREAM || valid_w)
         stall <= '0;
      else
         stall <= stall + 1'b1;
   end
`else
   // TIMEOUT only matters when the stall watchdog is built in.
   assign stall_expire = (TIMEOUT < 0);
`endif

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state      <= IDLE;
         ptr        <= '0;
         win        <= '0;
         count      <= '0;
         GNT        <= '0;
         DONE       <= '0;
         RESULT     <= '0;
         ABORT      <= 1'b0;
         DIN_READY  <= 1'b0;
         DP_CLEAR   <= 1'b0;
         DP_ENABLE  <= 1'b0;
         DP_RESTART <= 1'b0;
         DP_DATA    <= '0;
         BUSY       <= 1'b0;
      end else begin
         DONE       <= '0;
         ABORT      <= 1'b0;
         DP_CLEAR   <= 1'b0;
         DP_ENABLE  <= 1'b0;
         DP_RESTART <= 1'b0;
         if (abandon) begin
            ABORT     <= 1'b1;
            GNT       <= '0;
            ptr       <= win_next;
            DIN_READY <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (pick_valid) begin
                     win      <= pick;
                     GNT      <= NREQ'(1) << pick;
                     count    <= LEN[int'(pick)*LENW +: LENW];
                     DP_CLEAR <= 1'b1;
                     BUSY     <= 1'b1;
                     state    <= CLEAR;
                  end
               end
               CLEAR: begin
                  if (count == '0) begin
                     state <= RESTART;
                  end else begin
                     DIN_READY <= 1'b1;
                     state     <= STREAM;
                  end
               end
               STREAM: begin
                  DP_ENABLE <= valid_w;
                  DP_DATA   <= din_w;
                  if (valid_w) begin
                     count <= count - 1'b1;
                     if (count == LENW'(1)) begin
                        DIN_READY <= 1'b0;
                        state     <= RESTART;
                     end
                  end
               end
               // First RESTART cycle lets the last registered sample reach the datapath.
               RESTART: begin
                  if (!DP_RESTART)
                     DP_RESTART <= 1'b1;
                  else
                     state <= CAPTURE;
               end
               CAPTURE: begin
                  RESULT <= DP_OUT;
                  DONE   <= GNT;
                  GNT    <= '0;
                  ptr    <= win_next;
                  BUSY   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stat_sched.sv
// Directed bench for stat_sched with a behavioural running max/min/average datapath.
// Timeout cases are selected by STAT_SCHED_TIMEOUT_EN.
module tb_stat_sched;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int LENW    = 4;
   localparam int TIMEOUT = 16;

   logic                  CLOCK = 1'b0;
   logic                  RESET_N;
   logic [NREQ-1:0]       REQ;
   logic [NREQ*LENW-1:0]  LEN;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [NREQ-1:0]       DIN_VALID;
   logic                  DIN_READY;
   logic [NREQ-1:0]       GNT;
   logic [NREQ-1:0]       DONE;
   logic [WIDTH-1:0]      RESULT;
   logic                  ABORT;
   logic                  DP_CLEAR;
   logic                  DP_ENABLE;
   logic                  DP_RESTART;
   logic [WIDTH-1:0]      DP_DATA;
   logic [WIDTH-1:0]      DP_OUT;
   logic                  BUSY;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int cnt_clear, cnt_en, cnt_restart;
   logic [7:0] smp     [0:15];
   logic [7:0] en_data [0:15];

   logic signed [7:0] m_max = 8'sd0;
   logic signed [7:0] m_min = 8'sd0;
   logic [7:0]        dp_out_m = 8'h00;

   int lat, gw, ng, nd;
   logic [NREQ-1:0] dv, prev_gnt;
   logic            ab;
   logic [NREQ-1:0] gnt_log [0:3];
   logic [7:0]      res_log [0:3];
   logic [NREQ-1:0] exp_g   [0:3] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
   logic [7:0]      exp_r   [0:3] = '{8'h11, 8'h22, 8'h33, 8'h11};

   always #5 CLOCK = ~CLOCK;

   stat_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .REQ(REQ), .LEN(LEN), .DIN(DIN),
      .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .GNT(GNT), .DONE(DONE),
      .RESULT(RESULT), .ABORT(ABORT), .DP_CLEAR(DP_CLEAR), .DP_ENABLE(DP_ENABLE),
      .DP_RESTART(DP_RESTART), .DP_DATA(DP_DATA), .DP_OUT(DP_OUT), .BUSY(BUSY)
   );

   // Datapath stand-in: clear to empty extremes, track signed max/min, answer floor((max+min)/2).
   always @(posedge CLOCK) begin : dp_model
      logic signed [8:0] sum;
      sum = {m_max[7], m_max} + {m_min[7], m_min};
      if (DP_CLEAR) begin
         m_max <= -8'sd128;
         m_min <= 8'sd127;
      end else if (DP_ENABLE) begin
         if ($signed(DP_DATA) > m_max) m_max <= $signed(DP_DATA);
         if ($signed(DP_DATA) < m_min) m_min <= $signed(DP_DATA);
      end
      if (DP_RESTART) dp_out_m <= sum[8:1];
   end
   assign DP_OUT = dp_out_m;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(negedge CLOCK);
      cyc++;
      if (DP_CLEAR) cnt_clear++;
      if (DP_ENABLE) begin
         if (cnt_en < 16) en_data[cnt_en] = DP_DATA;
         cnt_en++;
      end
      if (DP_RESTART) cnt_restart++;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [NREQ-1:0] valid);
      REQ       = req;
      DIN_VALID = valid;
   endtask

   task automatic applyReset();
      RESET_N = 1'b0;
      applyStimulus('0, '0);
      LEN = '0;
      DIN = '0;
      stepCycle();
      stepCycle();
      RESET_N = 1'b1;
   endtask

   // Acts as requester w: waits for its grant, then streams smp[] honouring DIN_READY,
   // optionally withholding valid at sample stall_at or dropping REQ after drop_after samples.
   task automatic runSession(input string name, input int w, input int n, input int stall_at,
                             input int stall_len, input int drop_after, output int lat_o,
                             output int gw_o, output logic [NREQ-1:0] done_o, output logic ab_o);
      int   idx, stall, t_g;
      logic v, acc, sinc;
      LEN[w*LENW +: LENW] = LENW'(n);
      REQ[w]      = 1'b1;
      cnt_clear   = 0;
      cnt_en      = 0;
      cnt_restart = 0;
      gw_o        = 0;
      while (!GNT[w] && gw_o < 20) begin
         stepCycle();
         gw_o++;
      end
      checkOutput({name, "_gnt"}, 32'(GNT[w]), 32'd1);
      t_g   = cyc;
      idx   = 0;
      stall = 0;
      for (int k = 0; k < 400; k++) begin
         DIN[w*WIDTH +: WIDTH] = smp[idx & 15];
         v = !(idx == stall_at && stall < stall_len);
         if (drop_after >= 0 && idx == drop_after) REQ[w] = 1'b0;
         DIN_VALID[w] = v;
         acc  = DIN_READY && v && REQ[w];
         sinc = DIN_READY && !v;
         stepCycle();
         if (acc) idx++;
         if (sinc) stall++;
         if (DONE != '0 || ABORT) break;
      end
      lat_o  = cyc - t_g;
      done_o = DONE;
      ab_o   = ABORT;
      REQ[w]       = 1'b0;
      DIN_VALID[w] = 1'b0;
      checkOutput({name, "_end"}, 32'((DONE != '0) || ABORT), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] simulation hung");
   end

   initial begin
      applyReset();
      checkOutput("reset_outs", 32'({GNT, DONE, ABORT, BUSY, DIN_READY, DP_CLEAR, DP_ENABLE,
                                     DP_RESTART, RESULT, DP_DATA}), 32'd0);

      // Basic session: 0x10,0x30,0x20 -> avg(0x30,0x10) = 0x20, DONE 7 cycles after grant.
      smp[0] = 8'h10; smp[1] = 8'h30; smp[2] = 8'h20; smp[3] = 8'h00;
      runSession("s1", 0, 3, -1, 0, -1, lat, gw, dv, ab);
      checkOutput("s1_lat", lat, 7);
      checkOutput("s1_done", 32'(dv), 32'b0001);
      checkOutput("s1_result", 32'(RESULT), 32'h20);
      checkOutput("s1_clears", cnt_clear, 1);
      checkOutput("s1_enables", cnt_en, 3);
      checkOutput("s1_restarts", cnt_restart, 1);
      checkOutput("s1_data0", 32'(en_data[0]), 32'h10);
      checkOutput("s1_data1", 32'(en_data[1]), 32'h30);
      checkOutput("s1_data2", 32'(en_data[2]), 32'h20);
      checkOutput("s1_idle_busy", 32'(BUSY), 32'd0);

      // Round robin with requesters 0,1,3 held and LEN=1 each.
      applyReset();
      LEN = {4'd1, 4'd1, 4'd1, 4'd1};
      DIN = {8'h33, 8'h44, 8'h22, 8'h11};
      applyStimulus(4'b1011, 4'b1111);
      ng = 0;
      nd = 0;
      prev_gnt = '0;
      for (int k = 0; k < 80 && nd < 4; k++) begin
         stepCycle();
         if (GNT != '0 && prev_gnt == '0 && ng < 4) begin
            gnt_log[ng] = GNT;
            ng++;
         end
         prev_gnt = GNT;
         if (DONE != '0) begin
            res_log[nd] = RESULT;
            nd++;
         end
      end
      applyStimulus('0, '0);
      checkOutput("rr_sessions", nd, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr_gnt%0d", i), 32'(gnt_log[i]), 32'(exp_g[i]));
         checkOutput($sformatf("rr_res%0d", i), 32'(res_log[i]), 32'(exp_r[i]));
      end

      // Signed data: -16 and 8 -> -4, with and without a 3-cycle valid gap.
      smp[0] = 8'hF0; smp[1] = 8'h08; smp[2] = 8'h00;
      runSession("sg", 2, 2, -1, 0, -1, lat, gw, dv, ab);
      checkOutput("sg_lat", lat, 6);
      checkOutput("sg_result", 32'(RESULT), 32'hFC);
      runSession("sgap", 2, 2, 1, 3, -1, lat, gw, dv, ab);
      checkOutput("sgap_lat", lat, 9);
      checkOutput("sgap_result", 32'(RESULT), 32'hFC);

      // Zero-length burst: empty datapath answers avg(-128,127) = 0xFF.
      runSession("z", 0, 0, -1, 0, -1, lat, gw, dv, ab);
      checkOutput("z_lat", lat, 4);
      checkOutput("z_enables", cnt_en, 0);
      checkOutput("z_restarts", cnt_restart, 1);
      checkOutput("z_result", 32'(RESULT), 32'hFF);

      // Requester 1 drops REQ after 2 of 5 samples while requester 2 waits.
      LEN[2*LENW +: LENW] = 4'd1;
      REQ[2] = 1'b1;
      smp[0] = 8'h01; smp[1] = 8'h02; smp[2] = 8'h03; smp[3] = 8'h04; smp[4] = 8'h05;
      runSession("ab", 1, 5, -1, 0, 2, lat, gw, dv, ab);
      checkOutput("ab_abort", 32'(ab), 32'd1);
      checkOutput("ab_nodone", 32'(dv), 32'd0);
      checkOutput("ab_lat", lat, 4);
      checkOutput("ab_enables", cnt_en, 2);
      checkOutput("ab_result_kept", 32'(RESULT), 32'hFF);
      checkOutput("ab_gnt_clear", 32'(GNT), 32'd0);
      smp[0] = 8'h55;
      runSession("nx", 2, 1, -1, 0, -1, lat, gw, dv, ab);
      checkOutput("nx_gnt_wait", gw, 1);
      checkOutput("nx_done", 32'(dv), 32'b0100);
      checkOutput("nx_result", 32'(RESULT), 32'h55);

      smp[0] = 8'h40; smp[1] = 8'h60; smp[2] = 8'h00;
`ifdef STAT_SCHED_TIMEOUT_EN
      runSession("to16", 3, 2, 0, 16, -1, lat, gw, dv, ab);
      checkOutput("to16_abort", 32'(ab), 32'd1);
      checkOutput("to16_lat", lat, 17);
      checkOutput("to16_result_kept", 32'(RESULT), 32'h55);
      runSession("to15", 3, 2, 0, 15, -1, lat, gw, dv, ab);
      checkOutput("to15_done", 32'(dv), 32'b1000);
      checkOutput("to15_lat", lat, 21);
      checkOutput("to15_result", 32'(RESULT), 32'h50);
`else
      runSession("st100", 3, 2, 0, 100, -1, lat, gw, dv, ab);
      checkOutput("st100_done", 32'(dv), 32'b1000);
      checkOutput("st100_lat", lat, 106);
      checkOutput("st100_result", 32'(RESULT), 32'h50);
`endif

      // Reset mid-STREAM clears every output on the next edge.
      LEN[3*LENW +: LENW] = 4'd5;
      REQ[3]       = 1'b1;
      DIN_VALID[3] = 1'b1;
      for (int k = 0; k < 20 && !DIN_READY; k++) stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("pre_reset_busy", 32'(BUSY), 32'd1);
      RESET_N = 1'b0;
      stepCycle();
      checkOutput("midreset_outs", 32'({GNT, DONE, ABORT, BUSY, DIN_READY, DP_CLEAR, DP_ENABLE,
                                        DP_RESTART, RESULT, DP_DATA}), 32'd0);
      RESET_N = 1'b1;
      applyStimulus('0, '0);
      stepCycle();
      checkOutput("post_reset_gnt", 32'(GNT), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
